// File: rtl/viterbi_pkg.sv
// Shared types and default constants for the Viterbi BER checker.
package viterbi_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 64;
  localparam int unsigned DEF_CNT_W      = 32;
  localparam int unsigned DEF_WARMUP     = 0;
  localparam int unsigned DEF_WINDOW     = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/ber_ref_fifo.sv
// Reference-bit FIFO, first-word-fall-through head, one extra pointer bit for full/empty.
module ber_ref_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic full_c_o,
  output logic empty_c_o,
  output logic head_c_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0] mem_q;
  logic             do_push, do_pop;

  assign empty_c_o = (wr_q == rd_q);
  assign full_c_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_c_o  = mem_q[rd_q[AW-1:0]];
  // pop frees the slot first, so push on full is accepted when paired with a pop
  assign do_pop    = pop_i && !empty_c_o;
  assign do_push   = push_i && (!full_c_o || do_pop);

  // Pointer next-state; flush empties the FIFO
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents are don't-care while the FIFO is empty
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/viterbi_ber_checker.sv
// BER checker: buffers encoder input bits, compares them with decoder output over a window.
// Optional burst statistics enabled by defining BER_BURST_STATS_EN.
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned WARMUP     = DEF_WARMUP,
  parameter int unsigned WINDOW     = DEF_WINDOW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             ref_bit_i,
  input  logic             ref_valid_i,
  input  logic             dec_bit_i,
  input  logic             dec_valid_i,
  output logic [CNT_W-1:0] bits_checked_o,
  output logic [CNT_W-1:0] bit_errors_o,
`ifdef BER_BURST_STATS_EN
  output logic [CNT_W-1:0] burst_ct_o,
  output logic [CNT_W-1:0] max_burst_o,
`endif
  output logic             mismatch_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int unsigned WARM_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  state_e             state_q, state_d;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic [CNT_W-1:0]   checked_q, checked_d, errors_q, errors_d;
  logic               mism_q, mism_d, done_q, done_d;
  logic               ovf_q, ovf_d, udf_q, udf_d;
  logic               full_c, empty_c, head_c;
  logic               push_c, pop_c, cmp_c, err_c, udf_evt_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // FIFO control: DONE freezes traffic, clear dominates
  assign push_c    = ref_valid_i && (state_q != ST_DONE) && !clear_i;
  assign pop_c     = dec_valid_i && !empty_c && !clear_i &&
                     ((state_q == ST_WARMUP) || (state_q == ST_CHECK));
  assign udf_evt_c = dec_valid_i && empty_c && (state_q != ST_DONE) && !clear_i;
  assign cmp_c     = pop_c && (state_q == ST_CHECK);
  assign err_c     = cmp_c && (head_c != dec_bit_i);

  ber_ref_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (clear_i),
    .push_i    (push_c),
    .pop_i     (pop_c),
    .din_i     (ref_bit_i),
    .full_c_o  (full_c),
    .empty_c_o (empty_c),
    .head_c_o  (head_c)
  );

  // Next-state, counters and flags
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    checked_d = checked_q;
    errors_d  = errors_q;
    mism_d    = 1'b0;
    ovf_d     = ovf_q | (push_c && full_c && !pop_c);
    udf_d     = udf_q | udf_evt_c;
    unique case (state_q)
      ST_IDLE: begin
        if (ref_valid_i) state_d = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;
      end
      ST_WARMUP: begin
        if (pop_c) begin
          if (warm_q == WARM_W'(WARMUP - 1)) begin
            warm_d  = '0;
            state_d = ST_CHECK;
          end else begin
            warm_d = warm_q + WARM_W'(1);
          end
        end
      end
      ST_CHECK: begin
        if (cmp_c) begin
          checked_d = sat_inc(checked_q);
          if (err_c) begin
            errors_d = sat_inc(errors_q);
            mism_d   = 1'b1;
          end
          if (checked_d == CNT_W'(WINDOW)) state_d = ST_DONE;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
    if (clear_i) begin
      state_d   = ST_IDLE;
      warm_d    = '0;
      checked_d = '0;
      errors_d  = '0;
      mism_d    = 1'b0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end
    done_d = (state_d == ST_DONE);
  end

  // State and statistic registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      warm_q    <= '0;
      checked_q <= '0;
      errors_q  <= '0;
      mism_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      checked_q <= checked_d;
      errors_q  <= errors_d;
      mism_q    <= mism_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign bits_checked_o = checked_q;
  assign bit_errors_o   = errors_q;
  assign mismatch_o     = mism_q;
  assign done_o         = done_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

`ifdef BER_BURST_STATS_EN
  logic [CNT_W-1:0] bursts_q, bursts_d, maxb_q, maxb_d, run_q, run_d;
  logic             inb_q, inb_d;

  // Burst tracking over consecutive compared bits
  always_comb begin
    bursts_d = bursts_q;
    maxb_d   = maxb_q;
    run_d    = run_q;
    inb_d    = inb_q;
    if (cmp_c) begin
      if (err_c) begin
        run_d = inb_q ? sat_inc(run_q) : CNT_W'(1);
        if (!inb_q) bursts_d = sat_inc(bursts_q);
        if (run_d > maxb_q) maxb_d = run_d;
        inb_d = 1'b1;
      end else begin
        run_d = '0;
        inb_d = 1'b0;
      end
    end
    if (clear_i) begin
      bursts_d = '0;
      maxb_d   = '0;
      run_d    = '0;
      inb_d    = 1'b0;
    end
  end

  // Burst statistic registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bursts_q <= '0;
      maxb_q   <= '0;
      run_q    <= '0;
      inb_q    <= 1'b0;
    end else begin
      bursts_q <= bursts_d;
      maxb_q   <= maxb_d;
      run_q    <= run_d;
      inb_q    <= inb_d;
    end
  end

  assign burst_ct_o  = bursts_q;
  assign max_burst_o = maxb_q;
`else
  // burst statistics not built
`endif

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Directed bench: table of clean/error streams plus overflow, underflow, reset and burst sequences.
// Burst checks are compiled when BER_BURST_STATS_EN is defined.
module tb_viterbi_ber_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_i = 1'b0;
  logic        ref_bit_i = 1'b0, ref_valid_i = 1'b0;
  logic        dec_bit_i = 1'b0, dec_valid_i = 1'b0;
  logic [31:0] a_chk, a_err, b_chk, b_err;
  logic        a_mis, a_done, a_ovf, a_udf;
  logic        b_mis, b_done, b_ovf, b_udf;
`ifdef BER_BURST_STATS_EN
  logic [31:0] a_bct, a_bmax, b_bct, b_bmax;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  viterbi_ber_checker dut_a (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .ref_bit_i(ref_bit_i), .ref_valid_i(ref_valid_i),
    .dec_bit_i(dec_bit_i), .dec_valid_i(dec_valid_i),
    .bits_checked_o(a_chk), .bit_errors_o(a_err),
`ifdef BER_BURST_STATS_EN
    .burst_ct_o(a_bct), .max_burst_o(a_bmax),
`endif
    .mismatch_o(a_mis), .done_o(a_done), .overflow_o(a_ovf), .underflow_o(a_udf)
  );

  viterbi_ber_checker #(.FIFO_DEPTH(4), .WARMUP(5)) dut_b (
    .clk(clk), .rst(rst), .clear_i(clear_i),
    .ref_bit_i(ref_bit_i), .ref_valid_i(ref_valid_i),
    .dec_bit_i(dec_bit_i), .dec_valid_i(dec_valid_i),
    .bits_checked_o(b_chk), .bit_errors_o(b_err),
`ifdef BER_BURST_STATS_EN
    .burst_ct_o(b_bct), .max_burst_o(b_bmax),
`endif
    .mismatch_o(b_mis), .done_o(b_done), .overflow_o(b_ovf), .underflow_o(b_udf)
  );

  typedef struct {
    bit sel_b;        // 0: default instance, 1: FIFO_DEPTH=4/WARMUP=5 instance
    int mode;         // 0 clean, >0 every mode-th decoded bit inverted, -1 bits 10,11,12,40
    int lag;          // decoder lag in cycles
    int exp_checked;
    int exp_errors;   // also the expected number of mismatch pulses
    int exp_done_idx; // decoded-bit index after which done_o first reads high
  } vec_t;

  vec_t vecs[6];

  function automatic bit pat(input int i);
    logic [31:0] x;
    x = 32'(i) * 32'h9E37_79B1;
    return x[16] ^ x[7];
  endfunction

  function automatic bit err_at(input int mode, input int k);
    if (mode > 0) return ((k + 1) % mode) == 0;
    if (mode < 0) return (k == 10) || (k == 11) || (k == 12) || (k == 40);
    return 1'b0;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ref_valid_i = 1'b0; ref_bit_i = 1'b0;
    dec_valid_i = 1'b0; dec_bit_i = 1'b0;
    clear_i     = 1'b0;
  endtask

  task automatic do_clear();
    idle_inputs();
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
  endtask

  // Drive cycle c of a 300-bit stream with decoder lag and error pattern
  task automatic drive(input int c, input int lag, input int mode);
    int k;
    k = c - lag;
    ref_valid_i = (c < 300);
    ref_bit_i   = (c < 300) ? pat(c) : 1'b0;
    dec_valid_i = (k >= 0) && (k < 300);
    dec_bit_i   = dec_valid_i ? (pat(k) ^ err_at(mode, k)) : 1'b0;
  endtask

  task automatic run_check(input vec_t v, input bit clr, input string tag);
    int mism, done_idx, last;
    mism = 0; done_idx = -1; last = -1;
    if (clr) do_clear();
    for (int c = 0; c < 300 + v.lag + 8; c++) begin
      drive(c, v.lag, v.mode);
      @(posedge clk); #1;
      if (dec_valid_i) last = c - v.lag;
      if (v.sel_b ? b_mis : a_mis) mism++;
      if ((v.sel_b ? b_done : a_done) && done_idx < 0) done_idx = last;
    end
    idle_inputs();
    chk({tag, ".bits_checked"}, v.sel_b ? b_chk : a_chk, v.exp_checked);
    chk({tag, ".bit_errors"},   v.sel_b ? b_err : a_err, v.exp_errors);
    chk({tag, ".mismatch_pulses"}, mism, v.exp_errors);
    chk({tag, ".done_after_bit"}, done_idx, v.exp_done_idx);
    chk({tag, ".overflow"},  v.sel_b ? b_ovf : a_ovf, 0);
    chk({tag, ".underflow"}, v.sel_b ? b_udf : a_udf, 0);
  endtask

  initial begin
    vecs[0] = '{0,  0, 20, 256,  0, 255};
    vecs[1] = '{0,  8, 20, 256, 32, 255};
    vecs[2] = '{0,  3,  5, 256, 85, 255};
    vecs[3] = '{0, -1, 20, 256,  4, 255};
    vecs[4] = '{1,  0,  1, 256,  0, 260};
    vecs[5] = '{1,  8,  2, 256, 32, 260};

    // Reset state, observed before any clock edge
    #3;
    chk("rst.a_checked", a_chk, 0);
    chk("rst.a_errors", a_err, 0);
    chk("rst.a_flags", {a_mis, a_done, a_ovf, a_udf}, 0);
    chk("rst.b_flags", {b_mis, b_done, b_ovf, b_udf}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Decoded bit with nothing buffered
    do_clear();
    dec_valid_i = 1'b1; dec_bit_i = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    chk("udf.flag", a_udf, 1);
    chk("udf.checked", a_chk, 0);
    chk("udf.mismatch", a_mis, 0);

    // Table of measurement runs; each begins with clear_i
    for (int i = 0; i < 6; i++) begin
      run_check(vecs[i], 1'b1, $sformatf("vec%0d", i));
`ifdef BER_BURST_STATS_EN
      if (i == 3) begin
        chk("burst.count", a_bct, 2);
        chk("burst.max", a_bmax, 3);
      end
      if (i == 0) chk("burst.clean_count", a_bct, 0);
`endif
    end

    // Overflow on the 4-deep instance: 6 pushes, no pops
    do_clear();
    for (int p = 1; p <= 6; p++) begin
      ref_valid_i = 1'b1; ref_bit_i = p[0];
      @(posedge clk); #1;
      if (p == 4) chk("ovf.after_push4", b_ovf, 0);
      if (p == 5) chk("ovf.after_push5", b_ovf, 1);
    end
    idle_inputs();
    chk("ovf.checked", b_chk, 0);
    chk("ovf.errors", b_err, 0);
    do_clear();
    chk("ovf.cleared", b_ovf, 0);
    for (int p = 0; p < 4; p++) begin
      ref_valid_i = 1'b1; ref_bit_i = 1'b1;
      @(posedge clk); #1;
    end
    // full FIFO: simultaneous push and pop twice
    for (int p = 0; p < 2; p++) begin
      ref_valid_i = 1'b1; dec_valid_i = 1'b1;
      @(posedge clk); #1;
    end
    idle_inputs();
    chk("ovf.push_pop_full", b_ovf, 0);
    chk("ovf.push_pop_udf", b_udf, 0);

    // Reset in the middle of a run, then a fresh measurement without clear_i
    do_clear();
    for (int c = 0; c < 120; c++) begin
      drive(c, 20, 0);
      @(posedge clk); #1;
    end
    chk("midrst.before", a_chk, 100);
    drive(120, 20, 0);
    #2 rst = 1'b1;
    #1;
    chk("midrst.checked", a_chk, 0);
    chk("midrst.errors", a_err, 0);
    chk("midrst.flags", {a_mis, a_done, a_ovf, a_udf}, 0);
    idle_inputs();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run_check(vecs[0], 1'b0, "postrst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/viterbi_ber_checker.md
VITERBI_BER_CHECKER -- requirements
Module: viterbi_ber_checker

Interface
REQ-001 Parameter FIFO_DEPTH, default 64, depth of the reference-bit FIFO (power of two, >=4).
REQ-002 Parameter CNT_W, default 32, width of all statistic counters.
REQ-003 Parameter WARMUP, default 0, number of leading decoded bits discarded before comparison.
REQ-004 Parameter WINDOW, default 256, number of compared bits after which the measurement ends.
REQ-005 Port clk  input  1  single clock; all logic on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port clear_i  input  1  synchronous restart of the measurement.
REQ-008 Port ref_bit_i  input  1  bit presented to the convolutional encoder.
REQ-009 Port ref_valid_i  input  1  ref_bit_i is valid this cycle.
REQ-010 Port dec_bit_i  input  1  bit produced by the Viterbi decoder.
REQ-011 Port dec_valid_i  input  1  dec_bit_i is valid this cycle.
REQ-012 Port bits_checked_o  output  CNT_W  compared-bit count.
REQ-013 Port bit_errors_o  output  CNT_W  mismatch count.
REQ-014 Port mismatch_o  output  1  one-cycle pulse per mismatch.
REQ-015 Port done_o  output  1  measurement complete.
REQ-016 Port overflow_o  output  1  sticky, push into full FIFO.
REQ-017 Port underflow_o  output  1  sticky, decoded bit with empty FIFO.

Function
REQ-018 States IDLE, WARMUP, CHECK, DONE; encoding from the shared package.
REQ-019 IDLE -> WARMUP on first ref_valid_i; IDLE -> CHECK directly when WARMUP==0.
REQ-020 WARMUP: each dec_valid_i pops the FIFO head and discards it; after WARMUP pops -> CHECK.
REQ-021 CHECK: each dec_valid_i pops the head, compares with dec_bit_i, increments bits_checked_o, and on inequality increments bit_errors_o and pulses mismatch_o.
REQ-022 mismatch_o and counter updates are registered: visible the cycle after the dec_valid_i edge.
REQ-023 CHECK -> DONE on the edge at which bits_checked_o reaches WINDOW; done_o high from that cycle.
REQ-024 DONE: pushes, pops and counters frozen; only clear_i or rst leave DONE.
REQ-025 ref_valid_i pushes ref_bit_i in every state except DONE, including IDLE's leaving edge.
REQ-026 Simultaneous push and pop on a full FIFO is legal: pop then push, no overflow.
REQ-027 Push on full without pop: bit dropped, overflow_o set.
REQ-028 dec_valid_i on empty FIFO (simultaneous push not bypassed): no compare, no counter change, underflow_o set.
REQ-029 FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally; full/empty from the extra MSB.
REQ-030 Counters saturate at all-ones, never wrap.
REQ-031 clear_i: empties FIFO, zeroes counters and sticky flags, returns to IDLE; clear_i dominates coincident valids.

Reset
REQ-032 rst asserted: state IDLE, FIFO empty, all outputs 0, effective immediately without clk.
REQ-033 rst mid-measurement discards all data; first post-release ref_valid_i starts a fresh measurement.

Configuration
REQ-034 Macro BER_BURST_STATS_EN defined: outputs burst_ct_o (CNT_W, number of maximal runs of consecutive mismatches) and max_burst_o (CNT_W, longest run); both reset/cleared to 0, saturating, frozen in DONE.
REQ-035 Macro undefined: those ports and their logic are absent; all other behaviour identical.

Structure
REQ-036 Package viterbi_pkg holds the state enum type and default constants for FIFO_DEPTH, CNT_W, WARMUP, WINDOW.
REQ-037 Reference storage is a sub-module ber_ref_fifo (push/pop/full/empty, first-word-fall-through head).
REQ-038 Checker FSM and counters reside in viterbi_ber_checker.

Verification
REQ-039 Clean loop: 300 ref bits, decoded identical after 20-cycle lag -> bits_checked_o=256, bit_errors_o=0, done_o after bit 256.
REQ-040 Every 8th decoded bit inverted -> bit_errors_o=32 at done_o; 32 mismatch_o pulses.
REQ-041 WARMUP=5, clean stream -> first 5 decoded bits ignored; bits_checked_o reaches 256 at decoded bit 261.
REQ-042 FIFO_DEPTH=4, 6 pushes without pops -> overflow_o set on 5th push, counts unchanged; simultaneous push+pop at full -> no overflow.
REQ-043 dec_valid_i before any ref_valid_i -> underflow_o=1, bits_checked_o=0; clear_i then clean run -> underflow_o=0, normal result.
REQ-044 rst pulsed at bit 100 of a run -> outputs 0 immediately; BER_BURST_STATS_EN build with errors at bits 10,11,12,40 -> burst_ct_o=2, max_burst_o=3.
